// File: rtl/bkm_bus_master.sv
// Host-side initiator for the option-slot bus: sequences SEL/CMD/REG/DATA/END phases.
// Optional macro BKM_IRQ_SYNC_EN enables the 2-flop int_x synchroniser.
module bkm_bus_master #(
    parameter int SETUP_CYC = 4,
    parameter int HIGH_CYC  = 8,
    parameter int GAP_CYC   = 8
) (
    input  logic       clk_50mhz_in,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic       req_short,
    input  logic       req_slot_sel,
    input  logic [7:0] req_cmd,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       clk_rw,
    output logic       ax_d,
    output logic       r_wx,
    output logic       slot_x_int_x,
    output logic [7:0] data_out_x,
    output logic       data_oe_x,
    input  logic [7:0] data_in_x,
    input  logic       int_x,
    output logic       irq_pending
);

    localparam int PH   = SETUP_CYC + HIGH_CYC;
    localparam int CMAX = (PH > GAP_CYC) ? PH : GAP_CYC;
    localparam int CW   = $clog2(CMAX) + 1;

    typedef enum logic [2:0] {FLUSH, IDLE, SETUP, HIGH, GAP} state_e;
    typedef enum logic [2:0] {P_SEL, P_CMD, P_REG, P_DATA, P_END} phase_e;

    typedef struct packed {
        logic       ax;
        logic       rw;
        logic       slot;
        logic       oe;
        logic [7:0] dout;
    } bus_t;

    localparam bus_t BUS_RST = '{ax: 1'b1, rw: 1'b1, slot: 1'b1, oe: 1'b1, dout: 8'h00};
    localparam bus_t BUS_END = '{ax: 1'b0, rw: 1'b1, slot: 1'b1, oe: 1'b0, dout: 8'h00};

    function automatic bus_t phase_bus(phase_e p, logic wr, logic sel,
                                       logic [7:0] cmd, logic [7:0] rg,
                                       logic [7:0] wd);
        bus_t b;
        b = BUS_END;
        case (p)
            P_CMD: begin
                b.rw   = 1'b0;
                b.slot = ~sel;
                b.dout = ~cmd;
            end
            P_REG: begin
                b.rw   = 1'b0;
                b.slot = ~sel;
                b.dout = ~rg;
            end
            P_DATA: begin
                b.ax   = 1'b1;
                b.rw   = ~wr;
                b.slot = ~sel;
                b.oe   = ~wr;
                b.dout = wr ? ~wd : 8'h00;
            end
            default: b = BUS_END;
        endcase
        return b;
    endfunction

    state_e        state_q, state_d;
    phase_e        phase_q, phase_d, nxt;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    fl_q, fl_d;
    logic          clk_rw_q, clk_rw_d;
    bus_t          bus_q, bus_d;
    logic          rsp_q, rsp_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          wr_q, wr_d, sel_q, sel_d;
    logic [7:0]    cmd_q, cmd_d, reg_q, reg_d, wd_q, wd_d;

    always_ff @(posedge clk_50mhz_in) begin
        if (reset) begin
            state_q  <= FLUSH;
            phase_q  <= P_END;
            cnt_q    <= '0;
            fl_q     <= 2'd0;
            clk_rw_q <= 1'b0;
            bus_q    <= BUS_RST;
            rsp_q    <= 1'b0;
            rdata_q  <= 8'h00;
            wr_q     <= 1'b0;
            sel_q    <= 1'b0;
            cmd_q    <= 8'h00;
            reg_q    <= 8'h00;
            wd_q     <= 8'h00;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            fl_q     <= fl_d;
            clk_rw_q <= clk_rw_d;
            bus_q    <= bus_d;
            rsp_q    <= rsp_d;
            rdata_q  <= rdata_d;
            wr_q     <= wr_d;
            sel_q    <= sel_d;
            cmd_q    <= cmd_d;
            reg_q    <= reg_d;
            wd_q     <= wd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        fl_d     = fl_q;
        clk_rw_d = clk_rw_q;
        bus_d    = bus_q;
        rsp_d    = 1'b0;
        rdata_d  = rdata_q;
        wr_d     = wr_q;
        sel_d    = sel_q;
        cmd_d    = cmd_q;
        reg_d    = reg_q;
        wd_d     = wd_q;
        case (phase_q)
            P_SEL:   nxt = P_CMD;
            P_CMD:   nxt = P_REG;
            P_REG:   nxt = P_DATA;
            default: nxt = P_END;
        endcase
        case (state_q)
            FLUSH: begin
                // fl_q: 0 = not yet launched, 1/2 = first/second END phase
                if (fl_q == 2'd0) begin
                    fl_d     = 2'd1;
                    cnt_d    = '0;
                    phase_d  = P_END;
                    bus_d    = BUS_END;
                    clk_rw_d = 1'b0;
                end else if (cnt_q == CW'(PH - 1)) begin
                    cnt_d    = '0;
                    clk_rw_d = 1'b0;
                    if (fl_q == 2'd2) state_d = IDLE;
                    else fl_d = 2'd2;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(SETUP_CYC - 1)) clk_rw_d = 1'b1;
                end
            end
            IDLE: begin
                if (req_valid) begin
                    wr_d     = req_write;
                    sel_d    = req_slot_sel;
                    cmd_d    = req_cmd;
                    reg_d    = req_reg;
                    wd_d     = req_wdata;
                    phase_d  = req_short ? P_CMD : P_SEL;
                    bus_d    = phase_bus(phase_d, req_write, req_slot_sel,
                                         req_cmd, req_reg, req_wdata);
                    cnt_d    = '0;
                    clk_rw_d = 1'b0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(SETUP_CYC - 1)) begin
                    state_d  = HIGH;
                    clk_rw_d = 1'b1;
                    if (phase_q == P_DATA && !wr_q) rdata_d = ~data_in_x;
                end
            end
            HIGH: begin
                if (cnt_q == CW'(PH - 1)) begin
                    cnt_d    = '0;
                    clk_rw_d = 1'b0;
                    if (phase_q == P_END) begin
                        state_d = GAP;
                        rsp_d   = 1'b1;
                    end else begin
                        phase_d = nxt;
                        bus_d   = phase_bus(nxt, wr_q, sel_q, cmd_q, reg_q, wd_q);
                        state_d = SETUP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == CW'(GAP_CYC - 1)) state_d = IDLE;
                else cnt_d = cnt_q + CW'(1);
            end
            default: state_d = FLUSH;
        endcase
    end

    assign req_ready    = (state_q == IDLE);
    assign rsp_valid    = rsp_q;
    assign rsp_rdata    = rdata_q;
    assign clk_rw       = clk_rw_q;
    assign ax_d         = bus_q.ax;
    assign r_wx         = bus_q.rw;
    assign slot_x_int_x = bus_q.slot;
    assign data_oe_x    = bus_q.oe;
    assign data_out_x   = bus_q.dout;

`ifdef BKM_IRQ_SYNC_EN
    logic irq_s1_q, irq_s2_q;

    always_ff @(posedge clk_50mhz_in) begin
        if (reset) begin
            irq_s1_q <= 1'b0;
            irq_s2_q <= 1'b0;
        end else begin
            irq_s1_q <= ~int_x;
            irq_s2_q <= irq_s1_q;
        end
    end

    assign irq_pending = irq_s2_q;
`else
    logic unused_int_x;
    assign unused_int_x = int_x;
    assign irq_pending  = 1'b0;
`endif

endmodule

// File: tb/tb_bkm_bus_master.sv
// Bench for bkm_bus_master: random transactions against a phase-list reference model.
// Checks bus pulses, latency, read data, reset/flush behaviour and the irq path.
module tb_bkm_bus_master;

    localparam int S  = 4;
    localparam int H  = 8;
    localparam int G  = 8;
    localparam int PH = S + H;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0, req_write = 1'b0, req_short = 1'b0, req_slot_sel = 1'b0;
    logic [7:0] req_cmd = 8'h00, req_reg = 8'h00, req_wdata = 8'h00;
    logic       req_ready, rsp_valid, clk_rw, ax_d, r_wx, slot_x_int_x, data_oe_x;
    logic [7:0] rsp_rdata, data_out_x, data_in_x;
    logic       int_x = 1'b1;
    logic       irq_pending;
    logic [7:0] rbyte = 8'h00, noise = 8'h00;
    logic [7:0] last_rd = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bkm_bus_master #(.SETUP_CYC(S), .HIGH_CYC(H), .GAP_CYC(G)) dut (
        .clk_50mhz_in(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_short(req_short), .req_slot_sel(req_slot_sel),
        .req_cmd(req_cmd), .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .clk_rw(clk_rw), .ax_d(ax_d), .r_wx(r_wx), .slot_x_int_x(slot_x_int_x),
        .data_out_x(data_out_x), .data_oe_x(data_oe_x), .data_in_x(data_in_x),
        .int_x(int_x), .irq_pending(irq_pending)
    );

    // responder: drives the read byte only while the master has released a read DATA phase
    assign data_in_x = (ax_d && r_wx && data_oe_x) ? ~rbyte : noise;
    always @(posedge clk) noise <= 8'($urandom);

    // pulse record: {low cycles before rise, ax_d, r_wx, slot, oe, data_out_x}
    logic [19:0] mon_q[$];
    logic        prev_rw = 1'b0;
    int          lowcnt = 0;

    always @(negedge clk) begin
        if (clk_rw && !prev_rw)
            mon_q.push_back({8'(lowcnt), ax_d, r_wx, slot_x_int_x, data_oe_x, data_out_x});
        lowcnt  <= clk_rw ? 0 : lowcnt + 1;
        prev_rw <= clk_rw;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int hold, input string nm);
        int cyc;
        int rsp_seen;
        @(negedge clk);
        reset = 1'b1;
        req_valid = 1'b0;
        repeat (hold) @(negedge clk);
        check({nm, "_rstvals"},
              {8'h0, clk_rw, ax_d, r_wx, slot_x_int_x, data_oe_x, data_out_x,
               req_ready, rsp_valid, rsp_rdata, irq_pending},
              {8'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
        reset = 1'b0;
        last_rd = 8'h00;
        @(posedge clk);
        mon_q.delete();
        cyc = 1;
        rsp_seen = 0;
        @(negedge clk);
        while (!req_ready && cyc < 200) begin
            if (rsp_valid) rsp_seen++;
            @(negedge clk);
            cyc++;
        end
        check({nm, "_ready_cyc"}, cyc, 2 * PH + 1);
        check({nm, "_no_rsp"}, rsp_seen, 0);
        check({nm, "_npulse"}, mon_q.size(), 2);
        for (int i = 0; i < mon_q.size() && i < 2; i++) begin
            check($sformatf("%s_flush%0d", nm, i), mon_q[i][11:0], {4'b0110, 8'h00});
            if (i > 0) check($sformatf("%s_flush%0d_low", nm, i), mon_q[i][19:12], S);
        end
    endtask

    task automatic run_txn(input logic wr, input logic sh, input logic sel,
                           input logic [7:0] cmd, input logic [7:0] rg,
                           input logic [7:0] wd, input logic [7:0] rb,
                           input string nm);
        int          cyc, rsp_cyc, busy_ready;
        logic [11:0] exp_q[$];
        logic [11:0] got;
        cyc = 0;
        @(negedge clk);
        while (!req_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({nm, "_ready"}, req_ready, 1);
        rbyte        = rb;
        req_valid    = 1'b1;
        req_write    = wr;
        req_short    = sh;
        req_slot_sel = sel;
        req_cmd      = cmd;
        req_reg      = rg;
        req_wdata    = wd;
        @(posedge clk);
        mon_q.delete();
        cyc = 1;
        busy_ready = 0;
        @(negedge clk);
        while (!rsp_valid && cyc < 300) begin
            if (req_ready) busy_ready++;
            req_valid    = 1'($urandom);
            req_write    = 1'($urandom);
            req_short    = 1'($urandom);
            req_slot_sel = 1'($urandom);
            req_cmd      = 8'($urandom);
            req_reg      = 8'($urandom);
            req_wdata    = 8'($urandom);
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        rsp_cyc = cyc;
        check({nm, "_latency"}, rsp_cyc, (sh ? 4 : 5) * PH + 1);
        check({nm, "_busy_ready"}, busy_ready, 0);
        if (!wr) last_rd = rb;
        check({nm, "_rdata"}, rsp_rdata, last_rd);
        // expected bus content of each phase, in logical terms inverted onto the wire
        if (!sh) exp_q.push_back({4'b0110, 8'h00});
        exp_q.push_back({2'b00, ~sel, 1'b0, ~cmd});
        exp_q.push_back({2'b00, ~sel, 1'b0, ~rg});
        exp_q.push_back({1'b1, ~wr, ~sel, ~wr, wr ? ~wd : 8'h00});
        exp_q.push_back({4'b0110, 8'h00});
        check({nm, "_npulse"}, mon_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            got = mon_q[i][11:0];
            if (exp_q[i][8])
                check($sformatf("%s_p%0d", nm, i), got[11:8], exp_q[i][11:8]);
            else
                check($sformatf("%s_p%0d", nm, i), got, exp_q[i]);
            if (i > 0) check($sformatf("%s_p%0d_low", nm, i), mon_q[i][19:12], S);
        end
        @(negedge clk);
        cyc++;
        check({nm, "_rsp_pulse"}, rsp_valid, 0);
        while (!req_ready && cyc < rsp_cyc + 100) begin
            @(negedge clk);
            cyc++;
        end
        check({nm, "_gap"}, cyc, rsp_cyc + G);
    endtask

    initial begin
        do_reset(3, "por");
        run_txn(1'b1, 1'b0, 1'b0, 8'h21, 8'h00, 8'h04, 8'h00, "wr21");
        run_txn(1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 8'h00, 8'h88, "rd20");
        run_txn(1'b1, 1'b1, 1'b1, 8'h10, 8'h41, 8'hFF, 8'h00, "sw10");
        for (int i = 0; i < 8; i++)
            run_txn(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
                    8'($urandom), 8'($urandom), 8'($urandom), $sformatf("rnd%0d", i));

        // abort a read in the middle of its DATA phase
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        rbyte = 8'h5A;
        req_valid = 1'b1; req_write = 1'b0; req_short = 1'b0; req_slot_sel = 1'b1;
        req_cmd = 8'h20; req_reg = 8'h03;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (41) @(negedge clk);
        check("mid_in_data", ax_d, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_clk_rw", clk_rw, 0);
        check("mid_rsp", rsp_valid, 0);
        do_reset(2, "mid");
        run_txn(1'b0, 1'b0, 1'b1, 8'h20, 8'h07, 8'h00, 8'hC3, "rd_after");

`ifdef BKM_IRQ_SYNC_EN
        @(negedge clk);
        int_x = 1'b0;
        @(negedge clk);
        check("irq_f1", irq_pending, 0);
        @(negedge clk);
        check("irq_f2", irq_pending, 1);
        int_x = 1'b1;
        @(negedge clk);
        check("irq_r1", irq_pending, 1);
        @(negedge clk);
        check("irq_r2", irq_pending, 0);
`else
        @(negedge clk);
        int_x = 1'b0;
        repeat (4) @(negedge clk);
        check("irq_off", irq_pending, 0);
        int_x = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
